// File: rtl/demux_pkg.sv
// Shared select encodings and default widths for the 3-way stream mux/demux pair.
package demux_pkg;

   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_C    = 2'b10;
   localparam logic [1:0] SEL_DROP = 2'b11;

   localparam int DEFAULT_DW = 3;
   localparam int DEFAULT_CW = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry registered output slot with valid/ready handshake.
// A slot being drained can be refilled on the same edge, so there is no bubble.
module demux_slot
   import demux_pkg::*;
#(
   parameter int DW = DEFAULT_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          free
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (out_ready) begin
         // data is left in place after a drain
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign free      = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/stream_demux3.sv
// Routes one tagged input stream to three independent slotted output channels;
// words tagged SEL_DROP are consumed and counted in a saturating counter.
module stream_demux3
   import demux_pkg::*;
#(
   parameter int DW = DEFAULT_DW,
   parameter int CW = DEFAULT_CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] in_data,
   input  logic [1:0]    in_sel,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] a_data,
   output logic [DW-1:0] b_data,
   output logic [DW-1:0] c_data,
   output logic          a_valid,
   output logic          b_valid,
   output logic          c_valid,
   input  logic          a_ready,
   input  logic          b_ready,
   input  logic          c_ready,
   output logic [CW-1:0] drop_cnt
);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      if (c == {CW{1'b1}}) return c;
      return c + 1'b1;
   endfunction

   logic          free_a, free_b, free_c;
   logic          accept;
   logic          load_a, load_b, load_c;
   logic [CW-1:0] cnt_q, cnt_d;

   // Head-of-line: readiness depends only on the selected slot, never on in_valid.
   always_comb begin
      in_ready = 1'b1;
      case (in_sel)
         SEL_A:   in_ready = free_a;
         SEL_B:   in_ready = free_b;
         SEL_C:   in_ready = free_c;
         default: in_ready = 1'b1;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign load_a = accept && (in_sel == SEL_A);
   assign load_b = accept && (in_sel == SEL_B);
   assign load_c = accept && (in_sel == SEL_C);

   always_comb begin
      cnt_d = cnt_q;
      if (accept && (in_sel == SEL_DROP)) cnt_d = sat_inc(cnt_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign drop_cnt = cnt_q;

   demux_slot #(.DW(DW)) u_slot_a (
      .clk(clk), .rst_n(rst_n), .load(load_a), .load_data(in_data),
      .out_ready(a_ready), .out_valid(a_valid), .out_data(a_data), .free(free_a)
   );

   demux_slot #(.DW(DW)) u_slot_b (
      .clk(clk), .rst_n(rst_n), .load(load_b), .load_data(in_data),
      .out_ready(b_ready), .out_valid(b_valid), .out_data(b_data), .free(free_b)
   );

   demux_slot #(.DW(DW)) u_slot_c (
      .clk(clk), .rst_n(rst_n), .load(load_c), .load_data(in_data),
      .out_ready(c_ready), .out_valid(c_valid), .out_data(c_data), .free(free_c)
   );

endmodule

// File: tb/tb_stream_demux3.sv
// Bench for stream_demux3: cycle vector table, per-channel order scoreboard, reset sequences.
module tb_stream_demux3;

   localparam int DW = 3;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic [1:0]    in_sel;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a_data, b_data, c_data;
   logic          a_valid, b_valid, c_valid;
   logic          a_ready, b_ready, c_ready;
   logic [CW-1:0] drop_cnt;

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      int v, sel, d, ar, br, cr;
      int rdy, av, ad, bv, bd, cv, cd, cnt;
   } vec_t;

   vec_t          vecs[$];
   logic [DW-1:0] qa[$], qb[$], qc[$];

   always #5 clk = ~clk;

   stream_demux3 #(.DW(DW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
      .a_data(a_data), .b_data(b_data), .c_data(c_data),
      .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid),
      .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready),
      .drop_cnt(drop_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic missing(input string nm, input logic [31:0] act);
      nchk++;
      nerr++;
      $display("FAIL %s unexpected word actual=%0d required=none", nm, act);
   endtask

   // Scoreboard: push on accept, pop and compare on each consumer handshake.
   always @(posedge clk) begin
      if (rst_n) begin
         if (a_valid && a_ready) begin
            if (qa.size() == 0) missing("sb_a", 32'(a_data));
            else chk("sb_a", 32'(a_data), 32'(qa.pop_front()));
         end
         if (b_valid && b_ready) begin
            if (qb.size() == 0) missing("sb_b", 32'(b_data));
            else chk("sb_b", 32'(b_data), 32'(qb.pop_front()));
         end
         if (c_valid && c_ready) begin
            if (qc.size() == 0) missing("sb_c", 32'(c_data));
            else chk("sb_c", 32'(c_data), 32'(qc.pop_front()));
         end
         if (in_valid && in_ready) begin
            case (in_sel)
               2'b00:   qa.push_back(in_data);
               2'b01:   qb.push_back(in_data);
               2'b10:   qc.push_back(in_data);
               default: ;
            endcase
         end
      end
   end

   always @(negedge rst_n) begin
      qa.delete();
      qb.delete();
      qc.delete();
   end

   task automatic add(input int v, sel, d, ar, br, cr, rdy, av, ad, bv, bd, cv, cd, cnt);
      vec_t t;
      t = '{v, sel, d, ar, br, cr, rdy, av, ad, bv, bd, cv, cd, cnt};
      vecs.push_back(t);
   endtask

   task automatic apply(input vec_t t, input int i);
      @(negedge clk);
      in_valid = 1'(t.v);
      in_sel   = 2'(t.sel);
      in_data  = DW'(t.d);
      a_ready  = 1'(t.ar);
      b_ready  = 1'(t.br);
      c_ready  = 1'(t.cr);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), t.rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d a_valid", i), 32'(a_valid), t.av);
      chk($sformatf("v%0d a_data", i), 32'(a_data), t.ad);
      chk($sformatf("v%0d b_valid", i), 32'(b_valid), t.bv);
      chk($sformatf("v%0d b_data", i), 32'(b_data), t.bd);
      chk($sformatf("v%0d c_valid", i), 32'(c_valid), t.cv);
      chk($sformatf("v%0d c_data", i), 32'(c_data), t.cd);
      chk($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), t.cnt);
   endtask

   initial begin
      //   v sel d  ar br cr rdy av ad bv bd cv cd cnt
      // streaming to a
      add(1, 0, 1, 1, 1, 1, 1,  1, 1, 0, 0, 0, 0, 0);
      add(1, 0, 2, 1, 1, 1, 1,  1, 2, 0, 0, 0, 0, 0);
      add(1, 0, 3, 1, 1, 1, 1,  1, 3, 0, 0, 0, 0, 0);
      add(1, 0, 4, 1, 1, 1, 1,  1, 4, 0, 0, 0, 0, 0);
      add(1, 0, 5, 1, 1, 1, 1,  1, 5, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, 1, 1,  0, 5, 0, 0, 0, 0, 0);
      // interleaved routing
      add(1, 0, 1, 1, 1, 1, 1,  1, 1, 0, 0, 0, 0, 0);
      add(1, 1, 2, 1, 1, 1, 1,  0, 1, 1, 2, 0, 0, 0);
      add(1, 2, 3, 1, 1, 1, 1,  0, 1, 0, 2, 1, 3, 0);
      add(1, 0, 4, 1, 1, 1, 1,  1, 4, 0, 2, 0, 3, 0);
      add(0, 0, 0, 1, 1, 1, 1,  0, 4, 0, 2, 0, 3, 0);
      // backpressure on b, head-of-line blocks the following a word
      add(1, 1, 6, 1, 0, 1, 1,  0, 4, 1, 6, 0, 3, 0);
      add(1, 1, 7, 1, 0, 1, 0,  0, 4, 1, 6, 0, 3, 0);
      add(1, 1, 7, 1, 0, 1, 0,  0, 4, 1, 6, 0, 3, 0);
      add(1, 1, 7, 1, 1, 1, 1,  0, 4, 1, 7, 0, 3, 0);
      add(1, 0, 5, 1, 1, 1, 1,  1, 5, 0, 7, 0, 3, 0);
      add(0, 0, 0, 1, 1, 1, 1,  0, 5, 0, 7, 0, 3, 0);
      // drops and saturation at 2^CW-1
      add(1, 3, 1, 1, 1, 1, 1,  0, 5, 0, 7, 0, 3, 1);
      add(1, 3, 2, 1, 1, 1, 1,  0, 5, 0, 7, 0, 3, 2);
      add(1, 3, 3, 1, 1, 1, 1,  0, 5, 0, 7, 0, 3, 3);
      add(1, 3, 4, 1, 1, 1, 1,  0, 5, 0, 7, 0, 3, 3);
      add(1, 3, 5, 1, 1, 1, 1,  0, 5, 0, 7, 0, 3, 3);
      // stall c
      add(1, 2, 6, 1, 1, 0, 1,  0, 5, 0, 7, 1, 6, 3);
      add(1, 2, 1, 1, 1, 0, 0,  0, 5, 0, 7, 1, 6, 3);

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sel   = 2'b00;
      in_data  = '0;
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      c_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst a_valid", 32'(a_valid), 0);
      chk("rst b_valid", 32'(b_valid), 0);
      chk("rst c_valid", 32'(c_valid), 0);
      chk("rst a_data", 32'(a_data), 0);
      chk("rst drop_cnt", 32'(drop_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // reset while c is stalled with a blocked input word
      @(negedge clk);
      #2;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("rstc c_valid", 32'(c_valid), 0);
      chk("rstc c_data", 32'(c_data), 0);
      chk("rstc a_data", 32'(a_data), 0);
      chk("rstc b_data", 32'(b_data), 0);
      chk("rstc drop_cnt", 32'(drop_cnt), 0);
      chk("rstc in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_sel   = 2'b10;
      in_data  = 3'd2;
      #1;
      chk("post c in_ready", 32'(in_ready), 1);
      chk("post c_valid pre", 32'(c_valid), 0);
      @(posedge clk);
      #1;
      chk("post c_valid", 32'(c_valid), 1);
      chk("post c_data", 32'(c_data), 2);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("post c hold valid", 32'(c_valid), 1);
      chk("post c hold data", 32'(c_data), 2);

      // reset with a word sitting in slot a
      @(negedge clk);
      in_valid = 1'b1;
      in_sel   = 2'b00;
      in_data  = 3'd3;
      @(posedge clk);
      #1;
      chk("rsta a_valid pre", 32'(a_valid), 1);
      chk("rsta a_data pre", 32'(a_data), 3);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rsta a_valid", 32'(a_valid), 0);
      chk("rsta a_data", 32'(a_data), 0);
      chk("rsta c_valid", 32'(c_valid), 0);
      @(negedge clk);
      rst_n  = 1'b1;
      in_sel = 2'b11;
      #1;
      chk("rsta in_ready sel11", 32'(in_ready), 1);
      in_sel = 2'b00;
      #1;
      chk("rsta in_ready sel00", 32'(in_ready), 1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
